// File: rtl/vz_loader_pkg.sv
// Shared types and constants for the VZ image loader: FSM states,
// VZ header layout, file type codes and the write-port request struct.
package vz_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DRAIN,
    ST_PATCH_LO,
    ST_PATCH_HI,
    ST_RELEASE,
    ST_ERROR
  } vz_state_e;

  // VZ header: 24 bytes, type at 21, little-endian load address at 22/23
  localparam logic [15:0] HDR_LEN     = 16'd24;
  localparam logic [15:0] HDR_TYPE    = 16'd21;
  localparam logic [15:0] HDR_ADDR_LO = 16'd22;
  localparam logic [15:0] HDR_ADDR_HI = 16'd23;

  localparam logic [7:0]  VZ_TYPE_BASIC = 8'hF0;
  localparam logic [7:0]  VZ_TYPE_BIN   = 8'hF1;

  // BASIC end-of-program pointer (low byte here, high byte at +1)
  localparam logic [15:0] BASIC_END_PTR = 16'h78F9;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_req_t;

endpackage

// File: rtl/vz_byte_fifo.sv
// Small synchronous byte FIFO buffering payload between the download
// stream and the granted CPU bus. FIFO_DEPTH must be a power of two >= 2.
module vz_byte_fifo #(
  parameter  int FIFO_DEPTH = 4,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == CW'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign dout    = mem[rd_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // storage carries no reset so it can map onto a plain register file
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_q] <= din;
  end

  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/vz_loader_ctrl.sv
// VZ image loader: parses the header from the hps_io download stream, holds
// the CPU bus and writes the payload at the header load address.
// Optional VZ_BASIC_PTR_EN: after a BASIC (F0) load, patch the end pointer.
module vz_loader_ctrl
  import vz_loader_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] VZ_INDEX   = 8'd1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_download,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  input  logic [7:0]  dn_index,
  output logic        dn_wait,
  output logic        hold_req,
  input  logic        hold_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        busy,
  output logic        err,
  output logic [7:0]  vz_type
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  vz_state_e     state_q, state_d;
  logic          load, load_q, load_rise, grant;
  logic          hdr_done_q, hold_q, busy_q, err_q, dn_wait_q;
  logic          we_q, we_d;
  wr_req_t       wr_q, wr_d;
  logic [7:0]    type_q, start_lo_q;
  logic [15:0]   wptr_q;
  logic          flush, push, pop, full, empty;
  logic          hdr_wr, payload_wr, overrun;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count, count_nxt;

  assign load       = dn_download && (dn_index == VZ_INDEX);
  assign load_rise  = load && !load_q;
  assign grant      = hold_q && hold_ack;
  assign flush      = (state_q == ST_IDLE) && load_rise;
  assign hdr_wr     = (state_q == ST_HEADER) && load && dn_wr && !hdr_done_q &&
                      (dn_addr < HDR_LEN);
  assign payload_wr = (state_q == ST_HEADER) && load && dn_wr && hdr_done_q &&
                      (dn_addr >= HDR_LEN);
  assign push       = payload_wr && !full;
  assign overrun    = payload_wr && full;
  assign pop        = ((state_q == ST_HEADER) || (state_q == ST_DRAIN)) && grant && !empty;
  assign count_nxt  = flush ? '0 : fifo_count + CW'(push) - CW'(pop);

  vz_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .flush   (flush),
    .push    (push),
    .din     (dn_data),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // Edge detector is deliberately not reset: a download still running across
  // a reset must not be picked up again halfway through the file.
  always_ff @(posedge clk_sys) load_q <= load;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load_rise) state_d = ST_HEADER;
      ST_HEADER: if (!load)     state_d = hdr_done_q ? ST_DRAIN : ST_ERROR;
      ST_DRAIN: begin
        if (empty) begin
`ifdef VZ_BASIC_PTR_EN
          state_d = (type_q == VZ_TYPE_BASIC) ? ST_PATCH_LO : ST_RELEASE;
`else
          state_d = ST_RELEASE;
`endif
        end
      end
`ifdef VZ_BASIC_PTR_EN
      ST_PATCH_LO: if (grant) state_d = ST_PATCH_HI;
      ST_PATCH_HI: if (grant) state_d = ST_RELEASE;
`endif
      ST_RELEASE: state_d = ST_IDLE;
      ST_ERROR:   state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // wptr_q ends up one past the last written byte, i.e. the BASIC end pointer
  always_comb begin
    we_d = 1'b0;
    wr_d = wr_q;
    if (pop) begin
      we_d = 1'b1;
      wr_d = '{addr: wptr_q, data: fifo_dout};
    end
`ifdef VZ_BASIC_PTR_EN
    if (grant && state_q == ST_PATCH_LO) begin
      we_d = 1'b1;
      wr_d = '{addr: BASIC_END_PTR, data: wptr_q[7:0]};
    end
    if (grant && state_q == ST_PATCH_HI) begin
      we_d = 1'b1;
      wr_d = '{addr: BASIC_END_PTR + 16'd1, data: wptr_q[15:8]};
    end
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hdr_done_q <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      dn_wait_q  <= 1'b0;
      we_q       <= 1'b0;
      wr_q       <= '0;
      type_q     <= '0;
      start_lo_q <= '0;
      wptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != ST_IDLE);
      dn_wait_q <= (count_nxt >= CW'(FIFO_DEPTH - 1));
      we_q      <= we_d;
      wr_q      <= wr_d;
      if (flush) begin
        err_q      <= 1'b0;
        hdr_done_q <= 1'b0;
      end
      if (overrun || (state_q == ST_HEADER && state_d == ST_ERROR)) err_q <= 1'b1;
      if (hdr_wr) begin
        if (dn_addr == HDR_TYPE)    type_q     <= dn_data;
        if (dn_addr == HDR_ADDR_LO) start_lo_q <= dn_data;
        if (dn_addr == HDR_ADDR_HI) begin
          wptr_q     <= {dn_data, start_lo_q};
          hdr_done_q <= 1'b1;
          hold_q     <= 1'b1;
        end
      end
      if (pop) wptr_q <= wptr_q + 16'd1;
      if (state_q == ST_RELEASE || state_q == ST_ERROR) hold_q <= 1'b0;
    end
  end

  assign dn_wait   = dn_wait_q;
  assign hold_req  = hold_q;
  assign mem_addr  = wr_q.addr;
  assign mem_wdata = wr_q.data;
  assign mem_we    = we_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign vz_type   = type_q;

endmodule

// File: tb/tb_vz_loader_ctrl.sv
// Bench for vz_loader_ctrl: a write-list model of each load (address = start +
// index, mod 2^16) drained by a per-cycle compare process on every mem_we.
module tb_vz_loader_ctrl;

  localparam int         FIFO_DEPTH = 4;
  localparam logic [7:0] VZ_IDX     = 8'd1;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        dn_download = 1'b0;
  logic        dn_wr = 1'b0;
  logic [15:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic [7:0]  dn_index = '0;
  logic        hold_ack = 1'b0;
  logic        dn_wait, hold_req, mem_we, busy, err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, vz_type;

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  pl[$];
  logic [23:0] exp_w;
  int          ack_mode = 0;
  int          ack_cnt = 0;
  bit          saw_hold, saw_wait, saw_busy;

  vz_loader_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .VZ_INDEX(VZ_IDX)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .dn_download (dn_download),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_index    (dn_index),
    .dn_wait     (dn_wait),
    .hold_req    (hold_req),
    .hold_ack    (hold_ack),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .busy        (busy),
    .err         (err),
    .vz_type     (vz_type)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h, expected nothing", name, act);
  endtask

  // every write the DUT makes must be the next one the model predicts
  always @(negedge clk_sys) begin
    if (hold_req) saw_hold = 1'b1;
    if (dn_wait)  saw_wait = 1'b1;
    if (busy)     saw_busy = 1'b1;
    if (mem_we !== 1'b0) begin
      if (exp_q.size() == 0) fail_now("unexpected_write", {8'h0, mem_addr, mem_wdata});
      else begin
        exp_w = exp_q.pop_front();
        chk("write", {8'h0, mem_addr, mem_wdata}, {8'h0, exp_w});
        chk("hold_on_write", {31'h0, hold_req}, 32'h1);
      end
    end
  end

  // bus grant: 0 tied high, 1 random, 2 low for 10 cycles after hold_req, else low
  initial begin
    forever begin
      @(negedge clk_sys);
      case (ack_mode)
        0: hold_ack = 1'b1;
        1: hold_ack = ($urandom_range(3) != 0);
        2: begin
          if (hold_req) ack_cnt++;
          hold_ack = (ack_cnt > 10);
        end
        default: hold_ack = 1'b0;
      endcase
    end
  end

  task automatic send_byte(input logic [15:0] a, input logic [7:0] d, input bit respect, input int gap);
    int guard;
    for (int g = 0; g < gap; g++) @(negedge clk_sys);
    guard = 0;
    while (respect && dn_wait && guard < 200) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 200) fail_now("dn_wait_bound", 32'(guard));
    dn_addr = a;
    dn_data = d;
    dn_wr   = 1'b1;
    @(negedge clk_sys);
    dn_wr   = 1'b0;
  endtask

  task automatic send_header(input logic [7:0] typ, input logic [15:0] start);
    logic [7:0] d;
    dn_index    = VZ_IDX;
    dn_download = 1'b1;
    @(negedge clk_sys);
    for (int a = 0; a < 24; a++) begin
      d = 8'($urandom);
      if (a == 21) d = typ;
      if (a == 22) d = start[7:0];
      if (a == 23) d = start[15:8];
      send_byte(16'(a), d, 1'b0, 0);
    end
    chk("busy_in_load", {31'h0, busy}, 32'h1);
    chk("hold_after_hdr", {31'h0, hold_req}, 32'h1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk_sys);
    while (busy && guard < 1000) begin
      @(negedge clk_sys);
      guard++;
    end
    chk("idle_reached", {31'h0, busy}, 32'h0);
    chk("writes_left", 32'(exp_q.size()), 32'h0);
  endtask

  task automatic send_load(input logic [7:0] typ, input logic [15:0] start, input bit respect,
                           input int maxgap, input int ack_after);
    send_header(typ, start);
    for (int i = 0; i < pl.size(); i++)
      send_byte(16'(24 + i), pl[i], respect, (maxgap > 0) ? int'($urandom_range(maxgap)) : 0);
    if (ack_after >= 0) ack_mode = ack_after;
    dn_download = 1'b0;
    wait_idle();
  endtask

  // Model: payload byte i lands at start+i (mod 2^16); with ovr, the grant is
  // withheld for the whole payload so only the first FIFO_DEPTH bytes survive.
  task automatic build_exp(input logic [7:0] typ, input logic [15:0] start, input bit ovr);
    logic [15:0] a;
    bit          patch;
    a = start;
    for (int i = 0; i < pl.size(); i++) begin
      if (!ovr || i < FIFO_DEPTH) begin
        exp_q.push_back({a, pl[i]});
        a = a + 16'd1;
      end
    end
    patch = 1'b0;
`ifdef VZ_BASIC_PTR_EN
    patch = 1'b1;
`endif
    if (patch && typ == 8'hF0) begin
      exp_q.push_back({16'h78F9, a[7:0]});
      exp_q.push_back({16'h78FA, a[15:8]});
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  typ;
    logic [15:0] start;
    int          n;

    repeat (3) @(negedge clk_sys);
    chk("rst_dn_wait",   {31'h0, dn_wait},  32'h0);
    chk("rst_hold_req",  {31'h0, hold_req}, 32'h0);
    chk("rst_mem_addr",  {16'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    chk("rst_mem_we",    {31'h0, mem_we},   32'h0);
    chk("rst_busy",      {31'h0, busy},     32'h0);
    chk("rst_err",       {31'h0, err},      32'h0);
    chk("rst_vz_type",   {24'h0, vz_type},  32'h0);
    reset = 1'b0;
    @(negedge clk_sys);

    // binary load, grant tied high
    ack_mode = 0;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    build_exp(8'hF1, 16'h8000, 1'b0);
    chk("model_f1_size",  32'(exp_q.size()), 32'd4);
    chk("model_f1_first", {8'h0, exp_q[0]}, 32'h800011);
    chk("model_f1_last",  {8'h0, exp_q[3]}, 32'h800344);
    send_load(8'hF1, 16'h8000, 1'b1, 0, -1);
    chk("f1_err",  {31'h0, err}, 32'h0);
    chk("f1_type", {24'h0, vz_type}, 32'hF1);
    chk("f1_hold", {31'h0, hold_req}, 32'h0);

    // BASIC load (end pointer patch only when the option is built in)
    pl = '{8'h5A, 8'hA5};
    build_exp(8'hF0, 16'h7AE9, 1'b0);
    chk("model_f0_second", {8'h0, exp_q[1]}, 32'h7AEAA5);
`ifdef VZ_BASIC_PTR_EN
    chk("model_f0_ptr_lo", {8'h0, exp_q[2]}, 32'h78F9EB);
    chk("model_f0_ptr_hi", {8'h0, exp_q[3]}, 32'h78FA7A);
`endif
    send_load(8'hF0, 16'h7AE9, 1'b1, 0, -1);
    chk("f0_type", {24'h0, vz_type}, 32'hF0);
    chk("f0_err",  {31'h0, err}, 32'h0);

    // grant withheld 10 cycles: backpressure instead of loss
    ack_mode = 2;
    ack_cnt  = 0;
    saw_wait = 1'b0;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    build_exp(8'hF1, 16'h4000, 1'b0);
    send_load(8'hF1, 16'h4000, 1'b1, 0, -1);
    chk("stall_saw_wait", {31'h0, saw_wait}, 32'h1);
    chk("stall_err", {31'h0, err}, 32'h0);
    ack_mode = 0;

    // address wrap
    pl = '{8'hAA, 8'hBB, 8'hCC};
    build_exp(8'hF1, 16'hFFFE, 1'b0);
    chk("model_wrap_ffff", {8'h0, exp_q[1]}, 32'hFFFFBB);
    chk("model_wrap_0000", {8'h0, exp_q[2]}, 32'h0000CC);
    send_load(8'hF1, 16'hFFFE, 1'b1, 0, -1);

    // truncated header
    @(negedge clk_sys);
    saw_hold    = 1'b0;
    dn_index    = VZ_IDX;
    dn_download = 1'b1;
    @(negedge clk_sys);
    for (int a = 0; a < 10; a++) send_byte(16'(a), 8'($urandom), 1'b0, 0);
    dn_download = 1'b0;
    wait_idle();
    chk("trunc_err", {31'h0, err}, 32'h1);
    chk("trunc_no_hold", {31'h0, saw_hold}, 32'h0);

    // reset in the middle of the payload
    ack_mode = 3;
    send_header(8'hF1, 16'h6000);
    send_byte(16'd24, 8'h10, 1'b0, 0);
    send_byte(16'd25, 8'h20, 1'b0, 0);
    dn_addr = 16'd26;
    dn_data = 8'h30;
    dn_wr   = 1'b1;
    reset   = 1'b1;
    @(negedge clk_sys);
    dn_wr   = 1'b0;
    chk("midrst_hold",  {31'h0, hold_req}, 32'h0);
    chk("midrst_we",    {31'h0, mem_we}, 32'h0);
    chk("midrst_busy",  {31'h0, busy}, 32'h0);
    chk("midrst_err",   {31'h0, err}, 32'h0);
    chk("midrst_fifo",  32'(dut.u_fifo.count), 32'h0);
    dn_download = 1'b0;
    @(negedge clk_sys);
    reset    = 1'b0;
    ack_mode = 0;
    @(negedge clk_sys);
    pl = '{8'h77, 8'h88, 8'h99};
    build_exp(8'hF1, 16'h1234, 1'b0);
    send_load(8'hF1, 16'h1234, 1'b1, 0, -1);
    chk("after_rst_err", {31'h0, err}, 32'h0);

    // overrun: grant withheld, dn_wait ignored
    ack_mode = 3;
    pl = '{8'hE0, 8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    build_exp(8'hF1, 16'h5000, 1'b1);
    chk("model_ovr_size", 32'(exp_q.size()), 32'd4);
    send_load(8'hF1, 16'h5000, 1'b0, 0, 0);
    chk("ovr_err", {31'h0, err}, 32'h1);

    // foreign menu index is ignored
    saw_hold    = 1'b0;
    saw_busy    = 1'b0;
    dn_index    = 8'd2;
    dn_download = 1'b1;
    @(negedge clk_sys);
    for (int a = 0; a < 30; a++) send_byte(16'(a), 8'($urandom), 1'b0, 0);
    dn_download = 1'b0;
    repeat (5) @(negedge clk_sys);
    chk("other_idx_busy", {31'h0, saw_busy}, 32'h0);
    chk("other_idx_hold", {31'h0, saw_hold}, 32'h0);
    dn_index = VZ_IDX;

    // randomized loads with random grant and byte gaps
    ack_mode = 1;
    for (int k = 0; k < 10; k++) begin
      typ   = ($urandom_range(1) == 0) ? 8'hF0 : 8'hF1;
      start = ($urandom_range(3) == 0) ? 16'($urandom_range(16'hFFFF, 16'hFFF6)) : 16'($urandom);
      n     = int'($urandom_range(10));
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
      build_exp(typ, start, 1'b0);
      send_load(typ, start, 1'b1, 2, -1);
      chk("rand_err",  {31'h0, err}, 32'h0);
      chk("rand_type", {24'h0, vz_type}, {24'h0, typ});
      repeat (2) @(negedge clk_sys);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
